// File: rtl/pmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pmem_arbiter: round-robin I$/D$ line arbiter and 4-beat pmem sequencer   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pmem_arbiter #(
  parameter int LINE_BEATS = 4,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_read,
  input  logic [ADDR_WIDTH-1:0]              i_addr,
  output logic [LINE_BEATS*BEAT_WIDTH-1:0]   i_rdata,
  output logic                               i_resp,
  input  logic                               d_read,
  input  logic                               d_write,
  input  logic [ADDR_WIDTH-1:0]              d_addr,
  input  logic [LINE_BEATS*BEAT_WIDTH-1:0]   d_wdata,
  output logic [LINE_BEATS*BEAT_WIDTH-1:0]   d_rdata,
  output logic                               d_resp,
  output logic                               pmem_read,
  output logic                               pmem_write,
  output logic [ADDR_WIDTH-1:0]              pmem_addr,
  output logic [BEAT_WIDTH-1:0]              pmem_wdata,
  input  logic [BEAT_WIDTH-1:0]              pmem_rdata,
  input  logic                               pmem_resp
);

  localparam int c_line_w = LINE_BEATS * BEAT_WIDTH;
  localparam int c_cnt_w  = $clog2(LINE_BEATS);
  localparam int c_off_w  = $clog2(c_line_w / 8);
  localparam int c_idx_w  = $clog2(c_line_w);
  localparam logic [c_cnt_w-1:0]    c_last     = c_cnt_w'(LINE_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_off_mask = ADDR_WIDTH'((64'd1 << c_off_w) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_I_RD = 3'd1,
    S_D_RD = 3'd2,
    S_D_WR = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [c_cnt_w-1:0]      r_cnt;
  logic                    r_last_grant;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [c_line_w-1:0]     r_line;
  logic [c_line_w-1:0]     r_i_rdata;
  logic [c_line_w-1:0]     r_d_rdata;

  logic                    w_d_req;
  logic                    w_grant_data;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic                    w_in_burst;
  logic                    w_is_read;
  logic                    w_last_beat;
  logic [c_idx_w-1:0]      w_base;
  logic [c_line_w-1:0]     w_line_upd;

  assign w_d_req     = d_read | d_write;
  assign w_in_burst  = (r_state == S_I_RD) || (r_state == S_D_RD) || (r_state == S_D_WR);
  assign w_is_read   = (r_state == S_I_RD) || (r_state == S_D_RD);
  assign w_last_beat = w_in_burst && pmem_resp && (r_cnt == c_last);
  assign w_base      = c_idx_w'(r_cnt) * c_idx_w'(BEAT_WIDTH);
  assign w_sel_addr  = w_grant_data ? d_addr : i_addr;

  // Data wins a tie unless it was the last one served; writeback beats fill.
  always_comb begin
    w_next       = r_state;
    w_grant_data = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_d_req && (!i_read || !r_last_grant)) begin
          w_grant_data = 1'b1;
          w_next       = d_write ? S_D_WR : S_D_RD;
        end else if (i_read) begin
          w_next = S_I_RD;
        end
      end
      S_I_RD, S_D_RD, S_D_WR: begin
        if (w_last_beat) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_line_upd = r_line;
    w_line_upd[w_base +: BEAT_WIDTH] = pmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b0;
      r_addr       <= '0;
      r_line       <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (w_next != S_IDLE)) begin
        r_cnt        <= '0;
        r_last_grant <= w_grant_data;
        r_addr       <= w_sel_addr & ~c_off_mask;
      end
      if (w_in_burst && pmem_resp) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
        if (w_is_read) begin
          r_line <= w_line_upd;
        end
        // The final beat is merged directly so the line is complete in RESP.
        if (w_last_beat && (r_state == S_I_RD)) begin
          r_i_rdata <= w_line_upd;
        end
        if (w_last_beat && (r_state == S_D_RD)) begin
          r_d_rdata <= w_line_upd;
        end
      end
    end
  end

  assign pmem_read  = w_is_read;
  assign pmem_write = (r_state == S_D_WR);
  assign pmem_addr  = r_addr;
  assign pmem_wdata = (r_state == S_D_WR) ? d_wdata[w_base +: BEAT_WIDTH] : '0;
  assign i_resp     = (r_state == S_RESP) && !r_last_grant;
  assign d_resp     = (r_state == S_RESP) &&  r_last_grant;
  assign i_rdata    = r_i_rdata;
  assign d_rdata    = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pmem_arbiter: scoreboard bench with requester and pmem models         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pmem_arbiter;

  localparam int BW = 64;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [BW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  pmem_arbiter #(.LINE_BEATS(4), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          is_data;
    logic          is_write;
    logic [AW-1:0] addr;
    logic [LW-1:0] wline;
    logic [LW-1:0] rdata;
    int            resp_cyc;
  } exp_t;

  exp_t sb[$];
  int   rd_idx = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // pmem model: table or address-derived beats, programmable wait states
  int            waits = 0;
  logic          tbl_mode = 1'b0;
  logic [BW-1:0] tbl[4];
  int            m_beat = 0;
  int            m_wait = 0;

  function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a, input int b);
    if (tbl_mode) return tbl[b & 3];
    return {a, 8'hC0 + 8'(b & 3), 24'h5A5A5A};
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int b = 0; b < 4; b++) l[b*BW +: BW] = mem_word(a, b);
    return l;
  endfunction

  always @(negedge clk) begin
    if (pmem_read || pmem_write) begin
      if (rd_idx >= sb.size()) begin
        fail("burst_unexpected");
      end else begin
        check("burst_addr", LW'(pmem_addr), LW'(sb[rd_idx].addr));
        check("burst_dir", LW'({pmem_read, pmem_write}), LW'(sb[rd_idx].is_write ? 2'b01 : 2'b10));
        if (pmem_write)
          check("burst_wdata", LW'(pmem_wdata), LW'(sb[rd_idx].wline[(m_beat & 3)*BW +: BW]));
      end
      if (m_wait < waits) begin
        pmem_resp = 1'b0;
        m_wait++;
      end else begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_word(pmem_addr, m_beat);
        m_beat++;
        m_wait = 0;
      end
    end else begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      m_beat     = 0;
      m_wait     = 0;
    end
  end

  // Requester model plus response monitor: drop request on the resp edge
  int       i_tok = 0, i_seen = 0, d_tok = 0, d_seen = 0;
  logic [1:0] d_mode = 2'b01;

  always @(negedge clk) begin
    if (!rst) begin
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
      rd_idx  = sb.size();
    end else begin
      if (i_resp || d_resp) begin
        if (i_resp && d_resp) fail("resp_both");
        if (rd_idx >= sb.size()) begin
          fail("resp_unexpected");
        end else begin
          mon_e = sb[rd_idx];
          rd_idx++;
          check("resp_side", LW'(d_resp), LW'(mon_e.is_data));
          check("resp_cycle", LW'(cyc), LW'(mon_e.resp_cyc));
          if (mon_e.is_data) check("d_rdata", d_rdata, mon_e.rdata);
          else               check("i_rdata", i_rdata, mon_e.rdata);
        end
        if (i_resp) i_read = 1'b0;
        if (d_resp) begin
          d_read  = 1'b0;
          d_write = 1'b0;
        end
      end
      if (i_tok != i_seen) begin
        i_seen = i_tok;
        i_read = 1'b1;
      end
      if (d_tok != d_seen) begin
        d_seen  = d_tok;
        d_read  = d_mode[0];
        d_write = d_mode[1];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((rd_idx != sb.size()) && (n < max)) begin
      step();
      n++;
    end
    if (rd_idx != sb.size()) fail("drain_timeout");
  endtask

  function automatic exp_t mk(input logic is_d, input logic is_w, input logic [AW-1:0] a,
                              input logic [LW-1:0] wl, input logic [LW-1:0] rd, input int c);
    exp_t e;
    e.is_data = is_d; e.is_write = is_w; e.addr = a;
    e.wline = wl; e.rdata = rd; e.resp_cyc = c;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            k;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] exp_d;
    logic [LW-1:0] wl;

    exp_d = '0;
    repeat (2) step();
    check("rst_strobes", LW'({pmem_read, pmem_write, i_resp, d_resp}), '0);
    check("rst_addr", LW'(pmem_addr), '0);
    check("rst_wdata", LW'(pmem_wdata), '0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    rst = 1'b1;
    step();

    // Simultaneous reads from reset: D then I, four pairs, saturating
    tbl_mode = 1'b0;
    waits    = 0;
    for (int p = 0; p < 4; p++) begin
      k  = cyc;
      ia = 32'h0000_2000 + 32'(p) * 32'h100 + 32'h1F;
      da = 32'h4000_0000 + 32'(p) * 32'h240 + 32'h08;
      i_addr = ia;
      d_addr = da;
      d_mode = 2'b01;
      exp_d  = mem_line(da & ~32'h1F);
      sb.push_back(mk(1'b1, 1'b0, da & ~32'h1F, '0, exp_d, k + 5));
      sb.push_back(mk(1'b0, 1'b0, ia & ~32'h1F, '0, mem_line(ia & ~32'h1F), k + 11));
      i_tok++;
      d_tok++;
      repeat (12) step();
    end
    drain(40);

    // Single instruction fill with hand-computed beats
    tbl_mode = 1'b1;
    tbl[0] = 64'h1111_1111_1111_1111;
    tbl[1] = 64'h2222_2222_2222_2222;
    tbl[2] = 64'h3333_3333_3333_3333;
    tbl[3] = 64'h4444_4444_4444_4444;
    k = cyc;
    i_addr = 32'h0000_1234;
    sb.push_back(mk(1'b0, 1'b0, 32'h0000_1220, '0,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, k + 5));
    i_tok++;
    drain(40);

    // Writeback with two wait states before every beat
    waits   = 2;
    k       = cyc;
    wl      = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
               64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    d_addr  = 32'h8000_0040;
    d_wdata = wl;
    d_mode  = 2'b10;
    sb.push_back(mk(1'b1, 1'b1, 32'h8000_0040, wl, exp_d, k + 13));
    d_tok++;
    drain(60);
    waits = 0;

    // Read and write raised together: writeback goes first, d_rdata kept
    k       = cyc;
    wl      = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA};
    d_addr  = 32'h0000_5013;
    d_wdata = wl;
    d_mode  = 2'b11;
    sb.push_back(mk(1'b1, 1'b1, 32'h0000_5000, wl, exp_d, k + 5));
    d_tok++;
    drain(40);

    // Reset asserted mid-read after two beats
    tbl_mode = 1'b0;
    k = cyc;
    i_addr = 32'h0000_7700;
    sb.push_back(mk(1'b0, 1'b0, 32'h0000_7700, '0, mem_line(32'h0000_7700), k + 5));
    i_tok++;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("abort_strobes", LW'({pmem_read, pmem_write, i_resp, d_resp}), '0);
    check("abort_addr", LW'(pmem_addr), '0);
    check("abort_wdata", LW'(pmem_wdata), '0);
    check("abort_i_rdata", i_rdata, '0);
    check("abort_d_rdata", d_rdata, '0);
    step();
    rst = 1'b1;
    step();
    k = cyc;
    i_addr = 32'h0000_9A40;
    sb.push_back(mk(1'b0, 1'b0, 32'h0000_9A40, '0, mem_line(32'h0000_9A40), k + 5));
    i_tok++;
    drain(40);
    step();
    check("final_d_rdata", d_rdata, '0);
    check("final_idle", LW'({pmem_read, pmem_write}), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
